// File: rtl/pmc_pkg.sv
// Shared mode encoding, obstacle-sensor patterns and step width for the
// pmc_gen proportional motion controller.
package pmc_pkg;

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'd0,
        MODE_ASSIST = 2'd1,
        MODE_MANUAL = 2'd2,
        MODE_SAFE   = 2'd3
    } pmc_mode_e;

    localparam int unsigned STEP_W = 4;

    // Sensor patterns are {f1,f2,b1,b2}; the sensors are active low.
    localparam logic [3:0] SNS_FRONT_BLK = 4'b0011;
    localparam logic [3:0] SNS_REAR_BLK  = 4'b1100;
    localparam logic [3:0] SNS_F1        = 4'b0111;
    localparam logic [3:0] SNS_F2        = 4'b1011;
    localparam logic [3:0] SNS_RL        = 4'b0100;
    localparam logic [3:0] SNS_RR        = 4'b1000;

endpackage

// File: rtl/pmc_ramp.sv
// Single-axis slew limiter: moves cur toward tgt by at most step, never
// overshooting; o_at flags that the proposed value lands on the target.
module pmc_ramp
    import pmc_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]      i_cur,
    input  logic [W-1:0]      i_tgt,
    input  logic [STEP_W-1:0] i_step,
    output logic [W-1:0]      o_next,
    output logic              o_at
);

    logic [W-1:0] w_step;
    logic [W:0]   w_up;
    logic [W:0]   w_dn;
    logic [W-1:0] w_amt_up;
    logic [W-1:0] w_amt_dn;

    assign w_step = W'(i_step);

    // Distances are held in W+1 bits so the unused direction's wrap cannot alias.
    assign w_up = {1'b0, i_tgt} - {1'b0, i_cur};
    assign w_dn = {1'b0, i_cur} - {1'b0, i_tgt};

    assign w_amt_up = ({1'b0, w_step} < w_up) ? w_step : w_up[W-1:0];
    assign w_amt_dn = ({1'b0, w_step} < w_dn) ? w_step : w_dn[W-1:0];

    always_comb begin
        o_next = i_cur;
        if (i_tgt > i_cur) begin
            o_next = i_cur + w_amt_up;
        end else if (i_tgt < i_cur) begin
            o_next = i_cur - w_amt_dn;
        end
    end

    assign o_at = (o_next == i_tgt);

endmodule

// File: rtl/pmc_gen.sv
// Proportional motion controller: slews speed/direction toward mode- and
// sensor-dependent targets on a divided tick, with command watchdog.
module pmc_gen
    import pmc_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned DEF_SPEED = 40,
    parameter int unsigned DEF_DIR   = 128,
    parameter int unsigned TICK_DIV  = 4,
    parameter int unsigned WDOG      = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [W-1:0]      cmd_speed,
    input  logic [W-1:0]      cmd_dir,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic              f1,
    input  logic              f2,
    input  logic              b1,
    input  logic              b2,
    output logic [W-1:0]      speed_o,
    output logic [W-1:0]      dir_o,
    output logic              at_target,
    output logic              wdog_trip
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned WD_W  = $clog2(WDOG + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [WD_W-1:0]  WD_LIM   = WD_W'(WDOG);
    localparam logic [WD_W-1:0]  WD_PRE   = WD_W'(WDOG - 1);
    localparam logic [W-1:0]     SPD_DEF  = W'(DEF_SPEED);
    localparam logic [W-1:0]     DIR_DEF  = W'(DEF_DIR);
    localparam logic [W-1:0]     MAXV     = '1;

    logic [CNT_W-1:0] r_cnt;
    logic [WD_W-1:0]  r_wd;
    logic             r_wdog_trip;
    logic [W-1:0]     r_cmd_spd;
    logic [W-1:0]     r_cmd_dir;
    logic [W-1:0]     r_spd;
    logic [W-1:0]     r_dir;
    logic             r_at;

    pmc_mode_e        w_mode;
    logic             w_tick;
    logic             w_accept;
    logic             w_cmd_mode;
    logic [3:0]       w_sns;
    logic             w_sns_other;
    logic [W-1:0]     w_base_spd;
    logic [W-1:0]     w_base_dir;
    logic [W-1:0]     w_tgt_spd;
    logic [W-1:0]     w_tgt_dir;
    logic [W-1:0]     w_next_spd;
    logic [W-1:0]     w_next_dir;
    logic             w_at_spd;
    logic             w_at_dir;

    assign w_mode     = pmc_mode_e'(mode);
    assign cmd_ready  = en;
    assign w_accept   = cmd_valid & en;
    assign w_tick     = en & (r_cnt == CNT_LAST);
    assign w_cmd_mode = (w_mode == MODE_ASSIST) || (w_mode == MODE_MANUAL);
    assign w_sns      = {f1, f2, b1, b2};

    assign w_base_spd = w_cmd_mode ? r_cmd_spd : SPD_DEF;
    assign w_base_dir = w_cmd_mode ? r_cmd_dir : DIR_DEF;

    always_comb begin
        w_tgt_spd   = w_base_spd;
        w_tgt_dir   = w_base_dir;
        w_sns_other = 1'b0;
        if (w_mode != MODE_MANUAL) begin
            case (w_sns)
                SNS_FRONT_BLK: w_tgt_spd = '0;
                SNS_REAR_BLK:  w_tgt_spd = MAXV;
                SNS_F1:        w_tgt_dir = MAXV;
                SNS_F2:        w_tgt_dir = '0;
                SNS_RL: begin
                    w_tgt_spd = MAXV;
                    w_tgt_dir = MAXV;
                end
                SNS_RR: begin
                    w_tgt_spd = MAXV;
                    w_tgt_dir = '0;
                end
                default:       w_sns_other = 1'b1;
            endcase
        end
        // Safe mode stops on unrecognised patterns and never exceeds the base speed.
        if (w_mode == MODE_SAFE) begin
            if (w_sns_other) begin
                w_tgt_spd = '0;
            end else if (w_tgt_spd > SPD_DEF) begin
                w_tgt_spd = SPD_DEF;
            end
        end
        if (w_cmd_mode && r_wdog_trip) begin
            w_tgt_spd = '0;
            w_tgt_dir = r_dir;
        end
    end

    pmc_ramp #(.W(W)) u_ramp_spd (
        .i_cur  (r_spd),
        .i_tgt  (w_tgt_spd),
        .i_step (step),
        .o_next (w_next_spd),
        .o_at   (w_at_spd)
    );

    pmc_ramp #(.W(W)) u_ramp_dir (
        .i_cur  (r_dir),
        .i_tgt  (w_tgt_dir),
        .i_step (step),
        .o_next (w_next_dir),
        .o_at   (w_at_dir)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // An accepted command always wins over a same-cycle watchdog increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_spd   <= SPD_DEF;
            r_cmd_dir   <= DIR_DEF;
            r_wd        <= '0;
            r_wdog_trip <= 1'b0;
        end else if (w_accept) begin
            r_cmd_spd   <= cmd_speed;
            r_cmd_dir   <= cmd_dir;
            r_wd        <= '0;
            r_wdog_trip <= 1'b0;
        end else if (w_tick && w_cmd_mode && (r_wd != WD_LIM)) begin
            r_wd <= r_wd + WD_W'(1);
            if (r_wd == WD_PRE) begin
                r_wdog_trip <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spd <= '0;
            r_dir <= DIR_DEF;
            r_at  <= 1'b0;
        end else if (w_tick) begin
            r_spd <= w_next_spd;
            r_dir <= w_next_dir;
            r_at  <= w_at_spd & w_at_dir;
        end
    end

    assign speed_o   = r_spd;
    assign dir_o     = r_dir;
    assign at_target = r_at;
    assign wdog_trip = r_wdog_trip;

endmodule

// File: tb/tb_pmc_gen.sv
// Bench for pmc_gen: hand-derived scenario table plus randomized traffic
// checked every cycle against a behavioural model of the controller.
module tb_pmc_gen;

    localparam int W         = 8;
    localparam int MAXV      = 255;
    localparam int DEF_SPEED = 40;
    localparam int DEF_DIR   = 128;
    localparam int TICK_DIV  = 4;
    localparam int WDOG      = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_speed;
    logic [7:0] cmd_dir;
    logic [1:0] mode;
    logic [3:0] step;
    logic       f1, f2, b1, b2;
    logic [7:0] speed_o;
    logic [7:0] dir_o;
    logic       at_target;
    logic       wdog_trip;

    pmc_gen #(
        .W(W), .DEF_SPEED(DEF_SPEED), .DEF_DIR(DEF_DIR),
        .TICK_DIV(TICK_DIV), .WDOG(WDOG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_speed(cmd_speed), .cmd_dir(cmd_dir),
        .mode(mode), .step(step),
        .f1(f1), .f2(f2), .b1(b1), .b2(b2),
        .speed_o(speed_o), .dir_o(dir_o),
        .at_target(at_target), .wdog_trip(wdog_trip)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state.
    int m_spd, m_dir, m_cnt, m_wd, m_cs, m_cd;
    bit m_trip, m_at;

    typedef struct {
        int       mode;
        logic [3:0] sns;
        int       step;
        bit       cmd;
        int       cs;
        int       cd;
        int       ticks;
        int       e_spd;
        int       e_dir;
        bit       e_at;
        bit       e_trip;
    } row_t;

    row_t rows[21];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ramp(input int c, input int t, input int s);
        if (t > c) return c + ((s < t - c) ? s : t - c);
        if (t < c) return c - ((s < c - t) ? s : c - t);
        return c;
    endfunction

    task automatic model_reset();
        m_spd = 0; m_dir = DEF_DIR; m_cnt = 0; m_wd = 0;
        m_cs = DEF_SPEED; m_cd = DEF_DIR; m_trip = 0; m_at = 0;
    endtask

    task automatic targets(output int ts, output int td);
        int m;
        bit other;
        logic [3:0] s;
        m = int'(mode);
        s = {f1, f2, b1, b2};
        other = 0;
        ts = (m == 1 || m == 2) ? m_cs : DEF_SPEED;
        td = (m == 1 || m == 2) ? m_cd : DEF_DIR;
        if (m != 2) begin
            if (s == 4'b0011)      ts = 0;
            else if (s == 4'b1100) ts = MAXV;
            else if (s == 4'b0111) td = MAXV;
            else if (s == 4'b1011) td = 0;
            else if (s == 4'b0100) begin ts = MAXV; td = MAXV; end
            else if (s == 4'b1000) begin ts = MAXV; td = 0; end
            else other = 1;
        end
        if (m == 3) begin
            if (other) ts = 0;
            else if (ts > DEF_SPEED) ts = DEF_SPEED;
        end
        if ((m == 1 || m == 2) && m_trip) begin
            ts = 0;
            td = m_dir;
        end
    endtask

    // Advance the model across the coming clock edge using the present inputs.
    task automatic model_edge();
        int ts, td, ns, nd;
        bit tick;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!en) return;
        tick = (m_cnt == TICK_DIV - 1);
        targets(ts, td);
        if (tick) begin
            ns = ramp(m_spd, ts, int'(step));
            nd = ramp(m_dir, td, int'(step));
            m_at = (ns == ts) && (nd == td);
            m_spd = ns;
            m_dir = nd;
        end
        if (cmd_valid) begin
            m_cs = int'(cmd_speed);
            m_cd = int'(cmd_dir);
            m_wd = 0;
            m_trip = 0;
        end else if (tick && (mode == 2'd1 || mode == 2'd2)) begin
            if (m_wd < WDOG) m_wd++;
            if (m_wd == WDOG) m_trip = 1;
        end
        m_cnt = tick ? 0 : m_cnt + 1;
    endtask

    task automatic check_model();
        chk("model_speed", int'(speed_o), m_spd);
        chk("model_dir", int'(dir_o), m_dir);
        chk("model_at", int'(at_target), int'(m_at));
        chk("model_trip", int'(wdog_trip), int'(m_trip));
        chk("cmd_ready", int'(cmd_ready), int'(en));
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    initial begin
        row_t r;
        int seen;
        logic [3:0] pats[8];

        //          mode sns     step cmd cs   cd   ticks spd dir at trip
        rows[0]  = '{2, 4'b1111, 5,  1, 23,  130, 4,  20,  130, 0, 0};
        rows[1]  = '{2, 4'b1111, 5,  0, 0,   0,   1,  23,  130, 1, 0};
        rows[2]  = '{2, 4'b1111, 4,  1, 20,  130, 1,  20,  130, 1, 0};
        rows[3]  = '{2, 4'b1111, 4,  0, 0,   0,   6,  20,  130, 1, 0};
        rows[4]  = '{2, 4'b1111, 4,  0, 0,   0,   1,  20,  130, 1, 1};
        rows[5]  = '{2, 4'b1111, 4,  0, 0,   0,   1,  16,  130, 0, 1};
        rows[6]  = '{2, 4'b1111, 4,  0, 0,   0,   4,  0,   130, 1, 1};
        rows[7]  = '{2, 4'b1111, 5,  1, 23,  130, 1,  5,   130, 0, 0};
        rows[8]  = '{0, 4'b1111, 10, 0, 0,   0,   4,  40,  128, 1, 0};
        rows[9]  = '{0, 4'b0011, 3,  0, 0,   0,   13, 1,   128, 0, 0};
        rows[10] = '{0, 4'b0011, 3,  0, 0,   0,   1,  0,   128, 1, 0};
        rows[11] = '{0, 4'b0011, 3,  0, 0,   0,   2,  0,   128, 1, 0};
        rows[12] = '{1, 4'b0111, 15, 1, 60,  100, 4,  60,  188, 0, 0};
        rows[13] = '{1, 4'b0111, 15, 1, 60,  100, 5,  60,  255, 1, 0};
        rows[14] = '{1, 4'b0111, 15, 0, 0,   0,   2,  60,  255, 1, 0};
        rows[15] = '{3, 4'b1111, 7,  0, 0,   0,   3,  39,  234, 0, 0};
        rows[16] = '{3, 4'b1100, 7,  0, 0,   0,   2,  40,  220, 0, 0};
        rows[17] = '{3, 4'b0100, 0,  0, 0,   0,   2,  40,  220, 0, 0};
        rows[18] = '{0, 4'b0100, 15, 0, 0,   0,   3,  85,  255, 0, 0};
        rows[19] = '{0, 4'b1000, 15, 0, 0,   0,   1,  100, 240, 0, 0};
        rows[20] = '{2, 4'b0011, 15, 1, 100, 240, 1,  100, 240, 1, 0};

        pats[0] = 4'b0011; pats[1] = 4'b1100; pats[2] = 4'b0111; pats[3] = 4'b1011;
        pats[4] = 4'b0100; pats[5] = 4'b1000; pats[6] = 4'b1111; pats[7] = 4'b0000;

        rst_n = 1'b0; en = 1'b1; cmd_valid = 1'b0; cmd_speed = '0; cmd_dir = '0;
        mode = 2'd0; step = 4'd5; {f1, f2, b1, b2} = 4'b1111;
        model_reset();
        #12;
        chk("reset_speed", int'(speed_o), 0);
        chk("reset_dir", int'(dir_o), DEF_DIR);
        chk("reset_at", int'(at_target), 0);
        chk("reset_trip", int'(wdog_trip), 0);
        cyc();
        rst_n = 1'b1;

        // Ramp mode 0 toward 40, then reset asynchronously at speed 25.
        repeat (20) cyc();
        chk("pre_reset_speed", int'(speed_o), 25);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_reset_speed", int'(speed_o), 0);
        chk("async_reset_dir", int'(dir_o), DEF_DIR);
        chk("async_reset_trip", int'(wdog_trip), 0);
        cyc();
        rst_n = 1'b1;

        foreach (rows[i]) begin
            r = rows[i];
            mode = 2'(r.mode);
            {f1, f2, b1, b2} = r.sns;
            step = 4'(r.step);
            cmd_speed = 8'(r.cs);
            cmd_dir = 8'(r.cd);
            cmd_valid = r.cmd;
            seen = 0;
            for (int c = 0; c < 400 && seen < r.ticks; c++) begin
                if (m_cnt == TICK_DIV - 1) seen++;
                cyc();
                if (c == 0 && r.cmd) begin
                    cmd_valid = 1'b0;
                    chk($sformatf("row%0d_trip_after_accept", i), int'(wdog_trip), 0);
                end
            end
            chk($sformatf("row%0d_speed", i), int'(speed_o), r.e_spd);
            chk($sformatf("row%0d_dir", i), int'(dir_o), r.e_dir);
            chk($sformatf("row%0d_at", i), int'(at_target), int'(r.e_at));
            chk($sformatf("row%0d_trip", i), int'(wdog_trip), int'(r.e_trip));
        end

        // Freeze with en low at tick phase 2; tick resumes two enabled clocks later.
        mode = 2'd0; {f1, f2, b1, b2} = 4'b1111; step = 4'd1; cmd_valid = 1'b0;
        cyc();
        cyc();
        en = 1'b0;
        repeat (10) cyc();
        chk("freeze_speed", int'(speed_o), 100);
        chk("freeze_dir", int'(dir_o), 240);
        en = 1'b1;
        cyc();
        chk("resume_first_speed", int'(speed_o), 100);
        cyc();
        chk("resume_tick_speed", int'(speed_o), 99);
        chk("resume_tick_dir", int'(dir_o), 239);

        for (int n = 0; n < 4000; n++) begin
            en = ($urandom_range(0, 9) != 0);
            cmd_valid = ($urandom_range(0, 59) == 0);
            cmd_speed = 8'($urandom);
            cmd_dir = 8'($urandom);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 3) == 0) {f1, f2, b1, b2} = 4'($urandom);
                else {f1, f2, b1, b2} = pats[$urandom_range(0, 7)];
            end
            if ($urandom_range(0, 15) == 0) step = 4'($urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pmc_gen.md
Name: pmc_gen

Overview:
Parametrised successor to the 4-bit proportional motion controller. It drives speed_o/dir_o toward mode- and sensor-dependent targets, using a programmable slew step on a divided update tick. Adds over the previous generation:
- a command valid/ready handshake;
- a watchdog that stops the vehicle when remote commands cease;
- an at-target flag.
Sits between the command receiver and the motor driver, one instance per redundant lane.

Parameters:
W, 8, width of speed/dir paths; MAX = 2^W-1
DEF_SPEED, 40, base speed target in autonomous/safe modes
DEF_DIR, 128, centre direction; also the reset value of dir_o
TICK_DIV, 4, enabled clk cycles per update tick (>=1)
WDOG, 64, update ticks without an accepted command before watchdog trip (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  global enable; low freezes all state
cmd_valid  in  1  command present
cmd_ready  out  1  equals en (combinational)
cmd_speed  in  W  commanded speed
cmd_dir  in  W  commanded direction
mode  in  2  0 autonomous, 1 assisted, 2 manual, 3 safe
step  in  4  max change per tick; 0 = hold both axes
f1, f2, b1, b2  in  1 each  front/back obstacle sensors, active low
speed_o  out  W  registered speed
dir_o  out  W  registered direction
at_target  out  1  registered; both axes equal their targets
wdog_trip  out  1  registered watchdog flag

Behaviour:
- Reset (async, rst_n=0): speed_o=0, dir_o=DEF_DIR, at_target=0, wdog_trip=0, tick counter=0, watchdog counter=0, latched cmd_speed=DEF_SPEED, latched cmd_dir=DEF_DIR. A reset mid-ramp aborts the ramp immediately.
- en=0: every register holds, including tick phase and watchdog count.
- Tick counter runs 0..TICK_DIV-1 while en=1. tick = en & (cnt==TICK_DIV-1), then cnt wraps to 0.
- Command accept (cmd_valid & cmd_ready): latch cmd_speed/cmd_dir, clear the watchdog counter, clear wdog_trip. Flags and latches update on the next edge. A command accepted on a tick cycle is first used at the following tick.
- Base targets: modes 0 and 3 use DEF_SPEED/DEF_DIR; modes 1 and 2 use the latched command.
- Sensor table {f1,f2,b1,b2} (modes 0, 1, 3; mode 2 ignores sensors):
  - 0011: speed target 0, dir base.
  - 1100: speed target MAX, dir base.
  - 0111: speed base, dir target MAX.
  - 1011: speed base, dir target 0.
  - 0100: speed MAX, dir MAX.
  - 1000: speed MAX, dir 0.
  - Other patterns: base targets.
- Mode 3 overrides: speed target clamped to <= DEF_SPEED; "other" patterns give speed target 0.
- Watchdog (modes 1 and 2 only): increments once per tick, saturating at WDOG. Reaching WDOG sets wdog_trip. While tripped, speed target is 0 and dir target is the current dir_o. In modes 0 and 3 the counter holds and wdog_trip holds its value.
- Ramp per axis, on each tick:
  - next = cur + min(step, target-cur) if target > cur;
  - next = cur - min(step, cur-target) if target < cur;
  - otherwise cur.
  - Compute the difference in W+1 bits. The result can never overshoot the target or leave 0..MAX. Zero-extend step to W.
- at_target is updated each tick: 1 if both next values equal their targets.
- Latency: outputs change on the clk edge that samples tick. Mode or sensor changes take effect at the next tick without disturbing the outputs.

Decomposition:
- pmc_pkg holds:
  - mode enum (MODE_AUTO/ASSIST/MANUAL/SAFE);
  - sensor pattern constants (SNS_FRONT_BLK=4'b0011, SNS_REAR_BLK=4'b1100, SNS_F1=4'b0111, SNS_F2=4'b1011, SNS_RL=4'b0100, SNS_RR=4'b1000);
  - the ramp step width.
- One sub-module, pmc_ramp: single-axis slew limiter, parametrised by W, combinational next-value plus at-target bit. Instantiated twice (speed, dir).

Test Plan:
- Pulse rst_n low while speed_o=25 mid-ramp -> speed_o=0, dir_o=128, wdog_trip=0 asynchronously, before the next clk edge.
- Mode 2, step=5, accept cmd speed=23 dir=130 -> per tick (every 4 clks): speed 5,10,15,20,23; dir 130 at first tick; at_target=1 after the 5th tick.
- Mode 0, speed_o=40, sensors 0011, step=3 -> speed 37,34,...,4,1,0, then holds 0; dir stays 128; at_target=1 once 0 is reached.
- Mode 1, cmd speed=60 dir=100, sensors 0111, step=15 -> dir 115,130,...,250,255 then holds at 255; speed ramps to 60.
- WDOG=8, mode 2, speed 20, step=4, no commands -> wdog_trip=1 after the 8th tick, then speed 16,12,8,4,0. A new accepted command clears wdog_trip on the next edge.
- en low for 10 clks mid-ramp (cnt=2) -> outputs, cnt and watchdog frozen. After en returns, the next tick comes 2 enabled clks later.
